// File: rtl/uart_mmio_if.sv
// Data-memory port between the core's M stage and the UART peripheral.
// No valid/ready pair: a strobe (MemWrite lane or MemRead) qualified by CS is a
// single-cycle request that is always accepted on the rising edge it is sampled,
// and ReadData is a zero-latency combinational response in the same cycle.
interface uart_mmio_if;
  logic        CS;
  logic [1:0]  RegAddr;
  logic        MemRead;
  logic [3:0]  MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output CS, RegAddr, MemRead, MemWrite, WriteData,
    input  ReadData
  );

  modport slave (
    input  CS, RegAddr, MemRead, MemWrite, WriteData,
    output ReadData
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serializer, and a synchronized
// RX deserializer with a single holding register. Registers: 0 = DATA, 1 = STATUS.
module uart_mmio #(
  parameter int unsigned DIVISOR    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  uart_mmio_if.slave bus,
  output logic       TX,
  input  logic       RX,
  output logic       IRQ,
  output logic [1:0] dbg_tx_state_o,
  output logic [1:0] dbg_rx_state_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [15:0]   BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0]   HALF_LAST = 16'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic          push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Fullness uses the count at the start of the cycle, so a same-cycle pop frees no slot.
  assign push_req   = bus.CS & bus.MemWrite[0] & (bus.RegAddr == 2'd0);
  assign fifo_full  = (fifo_cnt_q == DEPTH_C);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_push  = push_req & ~fifo_full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= bus.WriteData[7:0];
  end

  // ---------------- TX serializer ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic        tx_tick, tx_empty;

  assign tx_tick  = (tx_cnt_q == BIT_LAST);
  assign tx_empty = fifo_empty & (tx_state_q == TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = fifo_mem_q[rd_ptr_q];
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          // Back-to-back frames: go straight to the next start bit.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_state_d = TX_START;
            tx_shift_d = fifo_mem_q[rd_ptr_q];
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // ---------------- RX deserializer ----------------
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_tick, rx_stop_ok, rx_stop_bad;

  assign rx_tick = (rx_cnt_q == BIT_LAST);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_stop_ok  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q & ~rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_cnt_d    = '0;
          rx_state_d  = RX_IDLE;
          rx_stop_ok  = rx_s2_q;
          rx_stop_bad = ~rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Flags and register file ----------------
  logic       rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic       tx_overflow_q, tx_overflow_d, rx_frame_err_q, rx_frame_err_d;
  logic       tx_ie_q, tx_ie_d, irq_q, irq_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       st_wr;
  logic [3:0] clr;
  logic [31:0] status;

  assign st_wr = bus.CS & bus.MemWrite[0] & (bus.RegAddr == 2'd1);
  assign clr   = st_wr ? bus.WriteData[5:2] : 4'b0000;

  // Each flag's set term is OR-ed after the clear, so a same-cycle set wins.
  always_comb begin
    rx_valid_d     = (rx_stop_ok & ~rx_valid_q) | (rx_valid_q & ~clr[0]);
    rx_overrun_d   = (rx_stop_ok & rx_valid_q)  | (rx_overrun_q & ~clr[1]);
    tx_overflow_d  = (push_req & fifo_full)     | (tx_overflow_q & ~clr[2]);
    rx_frame_err_d = rx_stop_bad                | (rx_frame_err_q & ~clr[3]);
    tx_ie_d        = st_wr ? bus.WriteData[6] : tx_ie_q;
    rx_data_d      = (rx_stop_ok & ~rx_valid_q) ? rx_shift_q : rx_data_q;
    irq_d          = rx_valid_q | (tx_empty & tx_ie_q);
  end

  assign status = {17'b0, 7'(fifo_cnt_q), 1'b0, tx_ie_q, rx_frame_err_q,
                   tx_overflow_q, rx_overrun_q, rx_valid_q, tx_empty, fifo_full};

  always_comb begin
    bus.ReadData = '0;
    if (bus.CS) begin
      case (bus.RegAddr)
        2'd0:    bus.ReadData = {24'b0, rx_data_q};
        2'd1:    bus.ReadData = status;
        default: bus.ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      tx_state_q     <= TX_IDLE;
      tx_cnt_q       <= '0;
      tx_bit_q       <= '0;
      tx_shift_q     <= '0;
      tx_q           <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_s1_q        <= 1'b1;
      rx_s2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      tx_overflow_q  <= 1'b0;
      rx_frame_err_q <= 1'b0;
      tx_ie_q        <= 1'b0;
      rx_data_q      <= '0;
      irq_q          <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_bit_q       <= tx_bit_d;
      tx_shift_q     <= tx_shift_d;
      tx_q           <= tx_d;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_s1_q        <= RX;
      rx_s2_q        <= rx_s1_q;
      rx_prev_q      <= rx_s2_q;
      rx_valid_q     <= rx_valid_d;
      rx_overrun_q   <= rx_overrun_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_frame_err_q <= rx_frame_err_d;
      tx_ie_q        <= tx_ie_d;
      rx_data_q      <= rx_data_d;
      irq_q          <= irq_d;
    end
  end

  assign TX             = tx_q;
  assign IRQ            = irq_q;
  assign dbg_tx_state_o = tx_state_q;
  assign dbg_rx_state_o = rx_state_q;

  // Reads have no side effects and only byte lane 0 carries register bits.
  logic unused_bus;
  assign unused_bus = &{1'b0, bus.MemRead, bus.MemWrite[3:1], bus.WriteData[31:8]};
endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register table, exact TX waveform, FIFO burst
// model, RX frames/faults, and reset in the middle of a frame.
module tb_uart_mmio;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       tx, rx, irq;
  logic [1:0] dbg_tx, dbg_rx;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_mmio_if bus ();

  uart_mmio #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET(rst), .bus(bus), .TX(tx), .RX(rx), .IRQ(irq),
    .dbg_tx_state_o(dbg_tx), .dbg_rx_state_o(dbg_rx)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus.CS = 1'b0; bus.RegAddr = 2'd0; bus.MemRead = 1'b0;
    bus.MemWrite = 4'b0; bus.WriteData = 32'h0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] mw);
    @(negedge clk);
    bus.CS = 1'b1; bus.RegAddr = a; bus.MemWrite = mw; bus.WriteData = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_rd(input logic cs, input logic [1:0] a, output logic [31:0] d);
    bus.CS = cs; bus.RegAddr = a; bus.MemRead = 1'b1;
    #1;
    d = bus.ReadData;
    bus_idle();
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  // ---------------- TX monitor + scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_t[$];
  logic       mon_en = 1'b0;

  initial begin : tx_monitor
    int         t0;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        t0 = cyc;
        repeat (DIV / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        got_q.push_back({tx, b});
        got_t.push_back(t0);
      end
    end
  end

  task automatic wait_frames(input int n, input int limit);
    for (int i = 0; i < limit && got_q.size() < n; i++) @(negedge clk);
    repeat (FRAME + 10) @(negedge clk);
  endtask

  task automatic score(input string name, input bit gapless);
    int n;
    check({name, " frames"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({name, " byte"}, 32'(got_q[i]), 32'(exp_q[i]));
      if (gapless && i > 0) check({name, " gap"}, got_t[i] - got_t[i-1], FRAME);
    end
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  // Reference model of a burst on consecutive cycles into an idle transmitter:
  // the shifter takes one byte the cycle after the first push and stays busy
  // far longer than any burst, and a push into a full FIFO is dropped.
  logic [7:0] burst_b[8];

  task automatic push_burst(input int n, output logic [31:0] st);
    int   occ = 0;
    int   dropped = 0;
    bit   busy = 0;
    bit   pop, full;
    logic [31:0] exp_st;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.CS = 1'b1; bus.RegAddr = 2'd0; bus.MemWrite = 4'b0001;
      bus.WriteData = {24'h0, burst_b[k]};
      full = (occ == DEPTH);
      pop  = (occ > 0) && !busy;
      if (pop) busy = 1;
      if (!full) begin
        exp_q.push_back({1'b1, burst_b[k]});
        occ++;
      end else begin
        dropped++;
      end
      if (pop) occ--;
    end
    @(negedge clk);
    bus_idle();
    bus_rd(1'b1, 2'd1, st);
    exp_st = (32'(occ) << 8) | ((dropped > 0) ? 32'h10 : 32'h0) | ((occ == DEPTH) ? 32'h1 : 32'h0);
    check("burst status", st, exp_st);
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  waddr;
    logic [3:0]  mw;
    logic [31:0] wdata;
    logic        rcs;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vt[12];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    logic [9:0]  fr;
    logic [7:0]  b;
    int          n;
    int          ones_bad;

    vt[0]  = '{1'b0, 2'd0, 4'b0000, 32'h00, 1'b1, 2'd1, 32'h02, 1'b0};
    vt[1]  = '{1'b0, 2'd0, 4'b0000, 32'h00, 1'b1, 2'd0, 32'h00, 1'b0};
    vt[2]  = '{1'b0, 2'd0, 4'b0000, 32'h00, 1'b1, 2'd2, 32'h00, 1'b0};
    vt[3]  = '{1'b0, 2'd0, 4'b0000, 32'h00, 1'b1, 2'd3, 32'h00, 1'b0};
    vt[4]  = '{1'b0, 2'd0, 4'b0000, 32'h00, 1'b0, 2'd1, 32'h00, 1'b0};
    vt[5]  = '{1'b1, 2'd1, 4'b0001, 32'h40, 1'b1, 2'd1, 32'h42, 1'b1};
    vt[6]  = '{1'b1, 2'd1, 4'b0001, 32'h3C, 1'b1, 2'd1, 32'h02, 1'b0};
    vt[7]  = '{1'b1, 2'd1, 4'b1110, 32'h40, 1'b1, 2'd1, 32'h02, 1'b0};
    vt[8]  = '{1'b1, 2'd2, 4'b0001, 32'hFF, 1'b1, 2'd1, 32'h02, 1'b0};
    vt[9]  = '{1'b1, 2'd1, 4'b0001, 32'h40, 1'b1, 2'd0, 32'h00, 1'b1};
    vt[10] = '{1'b1, 2'd1, 4'b0001, 32'h00, 1'b1, 2'd1, 32'h02, 1'b0};
    vt[11] = '{1'b1, 2'd3, 4'b0001, 32'h41, 1'b0, 2'd1, 32'h00, 1'b0};

    // Reset held for two cycles.
    rst = 1'b1; rx = 1'b1; bus_idle();
    repeat (2) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset irq", irq, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) bus_wr(vt[i].waddr, vt[i].wdata, vt[i].mw);
      @(negedge clk);
      bus_rd(vt[i].rcs, vt[i].raddr, rd);
      check($sformatf("table rd %0d", i), rd, vt[i].exp_rd);
      check($sformatf("table irq %0d", i), irq, vt[i].exp_irq);
    end

    // Single frame, exact waveform.
    fr = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back({1'b1, 8'hA5});
    bus_wr(2'd0, 32'hA5, 4'b0001);
    check("tx idle after push edge", tx, 1);
    bus_rd(1'b1, 2'd1, rd);
    check("status after push", rd, 32'h100);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      check($sformatf("tx wave %0d", i), tx, fr[i / DIV]);
    end
    bus_rd(1'b1, 2'd1, rd);
    check("tx_empty during stop end", rd, 32'h0);
    @(negedge clk);
    bus_rd(1'b1, 2'd1, rd);
    check("tx_empty after stop", rd, 32'h02);
    wait_frames(1, 2 * FRAME);
    score("single", 1'b0);

    // Fixed 6-byte burst into a 4-deep FIFO.
    for (int k = 0; k < 6; k++) burst_b[k] = 8'(k + 1);
    push_burst(6, rd);
    check("full burst literal", rd, 32'h411);
    wait_frames(5, 7 * FRAME);
    score("full burst", 1'b1);
    bus_wr(2'd1, 32'h10, 4'b0001);
    bus_rd(1'b1, 2'd1, rd);
    check("overflow cleared", rd, 32'h02);

    // Random bursts against the model.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < 8; k++) burst_b[k] = 8'($urandom_range(0, 255));
      push_burst(n, rd);
      wait_frames(exp_q.size(), (exp_q.size() + 2) * FRAME);
      score("rand burst", 1'b1);
      bus_wr(2'd1, 32'h10, 4'b0001);
      bus_rd(1'b1, 2'd1, rd);
      check("rand burst idle", rd, 32'h02);
    end

    // RX receive and overrun.
    rx_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    bus_rd(1'b1, 2'd1, rd); check("rx valid status", rd, 32'h06);
    bus_rd(1'b1, 2'd0, rd); check("rx data", rd, 32'h3C);
    check("rx irq", irq, 1);
    rx_frame(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    bus_rd(1'b1, 2'd1, rd); check("overrun status", rd, 32'h0E);
    bus_rd(1'b1, 2'd0, rd); check("overrun keeps data", rd, 32'h3C);
    bus_wr(2'd1, 32'h0C, 4'b0001);
    bus_rd(1'b1, 2'd1, rd); check("rx cleared", rd, 32'h02);
    @(negedge clk);
    check("irq cleared", irq, 0);

    // False start: one-cycle glitch.
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (20) @(negedge clk);
    bus_rd(1'b1, 2'd1, rd); check("glitch ignored", rd, 32'h02);

    // Framing error.
    rx_frame(8'h81, 1'b0);
    repeat (4) @(negedge clk);
    bus_rd(1'b1, 2'd1, rd); check("frame err status", rd, 32'h22);
    check("frame err irq", irq, 0);
    bus_wr(2'd1, 32'h20, 4'b0001);
    bus_rd(1'b1, 2'd1, rd); check("frame err cleared", rd, 32'h02);

    // Random RX bytes.
    for (int r = 0; r < 4; r++) begin
      b = 8'($urandom_range(0, 255));
      rx_frame(b, 1'b1);
      repeat (4) @(negedge clk);
      bus_rd(1'b1, 2'd1, rd); check("rand rx status", rd, 32'h06);
      bus_rd(1'b1, 2'd0, rd); check("rand rx data", rd, {24'h0, b});
      bus_wr(2'd1, 32'h04, 4'b0001);
      bus_rd(1'b1, 2'd1, rd); check("rand rx cleared", rd, 32'h02);
    end

    // Reset during DATA bit 3 of a TX frame, with a second byte queued.
    mon_en = 1'b0;
    bus_wr(2'd0, 32'h50, 4'b0001);
    bus_wr(2'd0, 32'h50, 4'b0001);
    repeat (15) @(negedge clk);
    check("tx bit3 before reset", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    check("tx after reset edge", tx, 1);
    bus_rd(1'b1, 2'd1, rd); check("status after mid reset", rd, 32'h02);
    rst = 1'b0;
    ones_bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) ones_bad++;
    end
    check("tx idle after reset", ones_bad, 0);
    check("got no frames while disabled", got_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral on the core's data-memory port, downstream of the M stage. It consumes the store strobe, byte mask, address and store data that the core emits, and returns read data to the core combinationally. The transmit path has a FIFO feeding an 8N1 serializer. The receive path has a synchronizer, a deserializer and a single holding register.

## Interface
- DIVISOR, 868: clock cycles per bit. The default gives 115200 baud at 100 MHz. Legal range is 4..65535.
- FIFO_DEPTH, 16: TX FIFO entries. Must be a power of two, 2..64.
- CLK  in  1  rising-edge clock; the only clock in the block.
- RESET  in  1  synchronous, active-high reset.
- CS  in  1  address-decoded select for this peripheral, valid in the same cycle as the strobes.
- RegAddr  in  2  word offset (address bits [3:2]). 0 = DATA, 1 = STATUS; 2 and 3 are reserved.
- MemRead  in  1  read strobe. Has no side effects.
- MemWrite  in  4  byte-enable mask. Only lane 0 is significant.
- WriteData  in  32  store data, already lane-aligned.
- ReadData  out  32  combinational read of the selected register. Returns 0 when CS=0 or RegAddr is reserved.
- TX  out  1  serial output, idles high.
- RX  in  1  serial input, asynchronous.
- IRQ  out  1  registered: rx_valid | (tx_empty & tx_ie).

## Operation
- **Write DATA:** a cycle with CS & MemWrite[0] & RegAddr==0 is one push of WriteData[7:0].
  - A push while the FIFO is full is dropped and sets tx_overflow.
  - Each strobed cycle counts as a separate push.
- **Read DATA:** returns {24'b0, rx_data}.
- **STATUS read layout:**
  - [0] tx_full
  - [1] tx_empty (FIFO empty and shifter idle)
  - [2] rx_valid
  - [3] rx_overrun
  - [4] tx_overflow
  - [5] rx_frame_err
  - [6] tx_ie
  - [14:8] tx_count
  - all other bits 0
- **STATUS write (lane 0):**
  - bits 2..5 are write-1-to-clear; clearing bit 2 consumes the RX byte.
  - bit 6 is written directly.
  - If a flag is set and cleared in the same cycle, the set wins.
- **TX FSM** (IDLE, START, DATA, STOP):
  - IDLE → START when the FIFO is non-empty. The head byte is popped into the shifter on that same edge.
  - Each state lasts DIVISOR cycles. DATA sends 8 bits, LSB first. STOP drives 1.
  - STOP → START directly if the FIFO is non-empty (no idle gap), otherwise STOP → IDLE.
  - A frame is exactly 10·DIVISOR cycles.
- **FIFO:** count ranges 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - Fullness is judged at the start of the cycle. A pop in the same cycle does not make room for a push.
  - Push and pop in the same cycle leave the count unchanged.
- **RX FSM** (IDLE, START, DATA, STOP):
  - RX passes through a 2-flop synchronizer; IDLE waits for a synchronized 1→0 transition.
  - START waits DIVISOR/2 cycles. If the line is high at that point, it is a false start and the FSM returns to IDLE.
  - DATA samples 8 bits at DIVISOR intervals, mid-bit, LSB first.
  - STOP samples one DIVISOR later:
    - 0 → sets rx_frame_err and discards the byte.
    - 1 with rx_valid=0 → loads rx_data and sets rx_valid.
    - 1 with rx_valid=1 → sets rx_overrun and discards the new byte; rx_data is kept.
  - The FSM returns to IDLE after STOP.
- **Reset values:**
  - TX=1, IRQ=0, FIFO empty, both FSMs in IDLE, synchronizer flops = 1.
  - All flags 0 and rx_data=0, so STATUS reads 0x00000002.
  - Reset mid-frame aborts it; TX is 1 from the cycle after the reset edge.

## Timing
- A push at edge N gives tx_count=1 after N.
  - If the shifter is idle, the pop and START happen at N+1, and TX=0 from N+1.
- tx_empty deasserts after N. It reasserts on the edge that ends the last STOP bit.
- The RX start-edge to rx_valid latency is 2 (sync) + DIVISOR/2 + 9·DIVISOR cycles, ±1.
- ReadData has zero latency and reflects register state before the current edge.
- IRQ is registered: it lags its source flags by one cycle.

## Test plan
- **Reset read:** assert RESET for 2 cycles, then read STATUS → 0x00000002; TX=1; IRQ=0.
- **Single TX frame** (DIVISOR=4): push 0xA5. Expect TX = 0 then bits 1,0,1,0,0,1,0,1, then 1, each held 4 cycles, 40 cycles total; afterwards STATUS[1]=1.
- **FIFO full and overflow** (DEPTH=4): push 6 bytes on consecutive cycles. First byte pops at N+1, so count peaks at 4 with tx_full=1. One push is dropped and tx_overflow=1. Exactly 5 frames are sent, with no gaps between them.
- **RX receive and overrun:** drive 0x3C at DIVISOR=4 → rx_valid=1, DATA=0x3C, IRQ=1. Drive 0x55 without clearing → rx_overrun=1 and DATA still 0x3C. Write STATUS=0x0C → rx_valid and rx_overrun both 0.
- **RX faults:** a 1-cycle low glitch on RX → no flag change (false start). A frame with the stop bit at 0 → rx_frame_err=1 and rx_valid stays 0.
- **Reset mid-frame:** assert RESET during DATA bit 3 of TX → TX=1 the next cycle, tx_count=0, and no further frame is sent.
